// File: rtl/add_sub_pkg.sv
// Shared types and constants for the add_sub datapath blocks.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_sub_state_t;

    localparam int ADD_SUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa.sv
// One-bit full adder cell.
// Purely combinational: zero latency, no flow control.
// Used as the serial bit slice of add_sub_serial_ctrl.
module fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/add_sub_serial_ctrl.sv
// Bit-serial add/subtract: one fa cell stepped LSB first through a carry flip-flop.
// Latency: start edge -> busy for WIDTH cycles -> done pulse in cycle WIDTH+1; one op per WIDTH+2 cycles.
// Backpressure: start ignored unless IDLE; optional abort port under ADD_SUB_SERIAL_ABORT_EN.
module add_sub_serial_ctrl
    import add_sub_pkg::*;
#(
    parameter int WIDTH = ADD_SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef ADD_SUB_SERIAL_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    add_sub_state_t   state;
    add_sub_state_t   state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry_ff;
    logic             fa_sum;
    logic             fa_carry;
    logic             abort_req;
    logic             last_bit;

`ifdef ADD_SUB_SERIAL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    fa u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry_ff),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign res_nxt  = {fa_sum, res_sh[WIDTH-1:1]};
    assign last_bit = (cnt == LAST);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_nxt = IDLE;
                end else if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: the +1 enters through the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            cnt       <= '0;
            carry_ff  <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh     <= op_a;
                        b_sh     <= sub ? ~op_b : op_b;
                        carry_ff <= sub;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        cnt <= '0;
                    end else begin
                        carry_ff <= fa_carry;
                        res_sh   <= res_nxt;
                        a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
                        b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
                        cnt      <= cnt + 1'b1;
                        if (last_bit) begin
                            // carry_ff here is the carry into the MSB
                            overflow  <= carry_ff ^ fa_carry;
                            carry_out <= fa_carry;
                            result    <= res_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_serial_ctrl.sv
// Directed bench for add_sub_serial_ctrl (WIDTH=8); abort scenario under ADD_SUB_SERIAL_ABORT_EN.
module tb_add_sub_serial_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
    logic       overflow;

    int n_checks;
    int n_fail;

    add_sub_serial_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef ADD_SUB_SERIAL_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {overflow, carry_out, result}
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [8:0] wide;
        logic [7:0] r;
        logic       co;
        logic       ov;
        if (s) begin
            r  = a - b;
            co = (a >= b);
            ov = (a[7] != b[7]) && (r[7] != a[7]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            r  = wide[7:0];
            co = wide[8];
            ov = (a[7] == b[7]) && (r[7] != a[7]);
        end
        return {ov, co, r};
    endfunction

    // Drives one operation from IDLE and reports what the DUT did; returns one cycle after done.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [7:0] r, output logic co, output logic ov,
                         output int busy_n, output int first_busy, output int done_cyc,
                         output logic done_after);
        int cyc;
        @(negedge clk);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; done_cyc = -1; busy_n = 0; first_busy = -1;
        r = 'x; co = 1'bx; ov = 1'bx;
        while (cyc <= 40 && done_cyc < 0) begin
            if (busy) begin
                busy_n++;
                if (first_busy < 0) first_busy = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                r = result; co = carry_out; ov = overflow;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0; abort = 1'b0;
        #12;
        n_checks++;
        if ({busy, done, result, carry_out, overflow} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h co=%b ov=%b, want all 0",
                     busy, done, result, carry_out, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_add_basic();
        logic [7:0] r; logic co, ov, da; int bn, fb, dc;
        do_op(8'h35, 8'h4A, 1'b0, r, co, ov, bn, fb, dc, da);
        n_checks++;
        if (fb !== 1 || bn !== 8) begin
            n_fail++;
            $display("FAIL add_busy_window: got first=%0d count=%0d, want 1 8", fb, bn);
        end
        n_checks++;
        if (dc !== 9) begin
            n_fail++;
            $display("FAIL add_done_cycle: got %0d, want 9", dc);
        end
        n_checks++;
        if (da !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done_single: done still %b after pulse, want 0", da);
        end
        n_checks++;
        if ({r, co, ov} !== {8'h7F, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_35_4a: got %h co=%b ov=%b, want 7f 0 0", r, co, ov);
        end
    endtask

    task automatic test_add_flags();
        logic [7:0] r; logic co, ov, da; int bn, fb, dc;
        do_op(8'h7F, 8'h01, 1'b0, r, co, ov, bn, fb, dc, da);
        n_checks++;
        if ({r, co, ov} !== {8'h80, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_7f_01: got %h co=%b ov=%b, want 80 0 1", r, co, ov);
        end
        do_op(8'hFF, 8'h01, 1'b0, r, co, ov, bn, fb, dc, da);
        n_checks++;
        if ({r, co, ov} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ff_01: got %h co=%b ov=%b, want 00 1 0", r, co, ov);
        end
        n_checks++;
        if (result !== 8'h00 || carry_out !== 1'b1) begin
            n_fail++;
            $display("FAIL result_hold: got %h co=%b in IDLE, want 00 1", result, carry_out);
        end
    endtask

    task automatic test_sub();
        logic [7:0] r; logic co, ov, da; int bn, fb, dc;
        do_op(8'h10, 8'h20, 1'b1, r, co, ov, bn, fb, dc, da);
        n_checks++;
        if ({r, co, ov} !== {8'hF0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_10_20: got %h co=%b ov=%b, want f0 0 0", r, co, ov);
        end
        do_op(8'h80, 8'h01, 1'b1, r, co, ov, bn, fb, dc, da);
        n_checks++;
        if ({r, co, ov} !== {8'h7F, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_80_01: got %h co=%b ov=%b, want 7f 1 1", r, co, ov);
        end
        do_op(8'hA5, 8'h00, 1'b1, r, co, ov, bn, fb, dc, da);
        n_checks++;
        if ({r, co, ov} !== {8'hA5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_b_zero: got %h co=%b ov=%b, want a5 1 0", r, co, ov);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [0:29];
        logic [7:0] vb [0:29];
        logic       vs [0:29];
        logic [9:0] exp;
        int         n_done;
        n_done = 0;
        for (int t = 0; t < 30; t++) begin
            va[t] = 8'(t * 37 + 11);
            vb[t] = 8'(t * 91 + 5);
            vs[t] = (t % 20) == 10;
        end
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (done) n_done++;
            if (t == 9 || t == 19 || t == 29) begin
                exp = model(va[t-9], vb[t-9], vs[t-9]);
                n_checks++;
                if (done !== 1'b1 || {overflow, carry_out, result} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_cycle%0d: got done=%b ov=%b co=%b r=%h, want done=1 ov=%b co=%b r=%h",
                             t, done, overflow, carry_out, result, exp[9], exp[8], exp[7:0]);
                end
            end
            if (t == 10) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle_gap: got busy=%b at cycle 10, want 0", busy);
                end
            end
            op_a = va[t]; op_b = vb[t]; sub = vs[t]; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (n_done !== 3) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d, want 3", n_done);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [7:0] r; logic co, ov, da; int bn, fb, dc;
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        op_a = 8'h35; op_b = 8'h4A; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, result, carry_out, overflow} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b result=%h co=%b ov=%b, want all 0",
                     busy, done, result, carry_out, overflow);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done/busy cycles, want 0", seen_done);
        end
        do_op(8'h01, 8'h01, 1'b0, r, co, ov, bn, fb, dc, da);
        n_checks++;
        if (dc !== 9 || r !== 8'h02) begin
            n_fail++;
            $display("FAIL post_reset_op: got done_cycle=%0d result=%h, want 9 02", dc, r);
        end
    endtask

`ifdef ADD_SUB_SERIAL_ABORT_EN
    task automatic test_abort();
        logic [7:0] r; logic co, ov, da; int bn, fb, dc;
        int seen;
        seen = 0;
        @(negedge clk);
        op_a = 8'h35; op_b = 8'h4A; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got busy=%b after abort, want 0", busy);
        end
        repeat (12) begin
            if (done) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 0 || result !== 8'h02) begin
            n_fail++;
            $display("FAIL abort_no_update: got done_cycles=%0d result=%h, want 0 02", seen, result);
        end
        do_op(8'h10, 8'h20, 1'b0, r, co, ov, bn, fb, dc, da);
        n_checks++;
        if (dc !== 9 || r !== 8'h30) begin
            n_fail++;
            $display("FAIL abort_followup: got done_cycle=%0d result=%h, want 9 30", dc, r);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add_basic();
        test_add_flags();
        test_sub();
        test_back_to_back();
        test_async_reset();
`ifdef ADD_SUB_SERIAL_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
